// File: rtl/tour_cmd_pkg.sv
// tour_cmd_pkg: shared states, opcodes, headings and limits for the tour command sequencer
package tour_cmd_pkg;
    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;
    localparam logic [3:0] OP_VERT = 4'h4;
    localparam logic [3:0] OP_HORZ = 4'h5;
    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST = 8'hBF;
    localparam logic [7:0] HDG_WEST = 8'h3F;
    localparam logic [4:0] LAST_MOVE = 5'd23;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;
endpackage

// File: rtl/tour_move_decode.sv
// tour_move_decode: one-hot knight move to vertical and horizontal leg commands
module tour_move_decode
    import tour_cmd_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert,
    output logic [15:0] horz
);
    logic [2:0] idx;
    logic any, dx_neg, dy_neg, dx_two, dy_two;
    // scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) if (move[i]) idx = 3'(i);
    end
    assign any = |move;
    assign dx_neg = idx inside {3'd1, 3'd2, 3'd3, 3'd4};
    assign dy_neg = idx inside {3'd3, 3'd4, 3'd5, 3'd6};
    assign dx_two = idx inside {3'd2, 3'd3, 3'd6, 3'd7};
    assign dy_two = idx inside {3'd0, 3'd1, 3'd4, 3'd5};
    assign vert = {OP_VERT, dy_neg ? HDG_SOUTH : HDG_NORTH, 2'b00, any & dy_two, any & ~dy_two};
    assign horz = {OP_HORZ, dx_neg ? HDG_WEST : HDG_EAST, 2'b00, any & dx_two, any & ~dx_two};
endmodule

// File: rtl/tour_cmd.sv
// tour_cmd: replays a solved knight's tour as vert/horz commands; TOUR_CMD_UART_ABORT_EN lets a UART command abort it
module tour_cmd
    import tour_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);
    state_t state, nxt;
    logic [4:0] idx_d;
    logic rdy_q, rdy_d;
    logic [7:0] move_q;
    logic [15:0] vert, horz;
    // after VERT the captured move keeps cmd stable even if the tour memory output changes
    tour_move_decode u_dec (.move(state == VERT ? move : move_q), .vert(vert), .horz(horz));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mv_indx <= '0;
            rdy_q <= 1'b0;
            move_q <= '0;
        end else begin
            state <= nxt;
            mv_indx <= idx_d;
            rdy_q <= rdy_d;
            move_q <= state == VERT ? move : move_q;
        end
    end
    always_comb begin
        nxt = state;
        idx_d = mv_indx;
        case (state)
            IDLE: if (start_tour) begin
                nxt = VERT;
                idx_d = '0;
            end
            VERT: if (clr_cmd_rdy) nxt = WAIT_V;
            WAIT_V: if (send_resp) nxt = HORZ;
            HORZ: if (clr_cmd_rdy) nxt = WAIT_H;
            WAIT_H: if (send_resp) begin
                nxt = mv_indx == LAST_MOVE ? IDLE : VERT;
                idx_d = mv_indx == LAST_MOVE ? mv_indx : mv_indx + 5'd1;
            end
            default: nxt = IDLE;
        endcase
`ifdef TOUR_CMD_UART_ABORT_EN
        if (state != IDLE && cmd_rdy_UART) begin
            nxt = IDLE;
            idx_d = '0;
        end
`endif
        rdy_d = nxt == IDLE ? 1'b0 : (nxt != state && (nxt == VERT || nxt == HORZ)) ? 1'b1 : clr_cmd_rdy ? 1'b0 : rdy_q;
    end
    assign cmd = state == IDLE ? cmd_UART : (state == VERT || state == WAIT_V) ? vert : horz;
    assign cmd_rdy = state == IDLE ? cmd_rdy_UART : rdy_q;
    assign clr_cmd_rdy_UART = state == IDLE && clr_cmd_rdy;
    assign resp = (state == IDLE || (state == WAIT_H && mv_indx == LAST_MOVE)) ? RESP_DONE : RESP_BUSY;
endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: directed vectors for tour_cmd; honours TOUR_CMD_UART_ABORT_EN
module tb_tour_cmd;
    logic clk, rst, start_tour, cmd_rdy_UART, clr_cmd_rdy, send_resp;
    logic clr_cmd_rdy_UART, cmd_rdy;
    logic [7:0] move, resp, noise;
    logic [4:0] mv_indx;
    logic [15:0] cmd_UART, cmd;
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mvs [12] = '{8'h01, 8'h10, 8'h06, 8'h00, 8'h02, 8'h04, 8'h08, 8'h20, 8'h40, 8'h80, 8'hC0, 8'h18};
    logic [15:0] vx [12] = '{16'h4002, 16'h47F2, 16'h4002, 16'h4000, 16'h4002, 16'h4001,
                             16'h47F1, 16'h47F2, 16'h47F1, 16'h4001, 16'h47F1, 16'h47F1};
    logic [15:0] hx [12] = '{16'h5BF1, 16'h53F1, 16'h53F1, 16'h5BF0, 16'h53F1, 16'h53F2,
                             16'h53F2, 16'h5BF1, 16'h5BF2, 16'h5BF2, 16'h5BF2, 16'h53F2};
    logic [7:0] tour [32];

    tour_cmd dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign move = tour[mv_indx] ^ noise;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resp_step();
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
    endtask

    // enters in VERT, leaves in WAIT_V
    task automatic do_vert(input int idx);
        noise = 8'h00;
        #1;
        check("v_cmd", cmd, vx[idx % 12]);
        check("v_rdy", 16'(cmd_rdy), 16'd1);
        check("v_idx", 16'(mv_indx), 16'(idx));
        check("v_resp", 16'(resp), 16'h5A);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        check("v_ign_resp", 16'(cmd_rdy), 16'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        check("v_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
        step();
        clr_cmd_rdy = 1'b0;
        noise = 8'hFF;
        #1;
        check("wv_cmd", cmd, vx[idx % 12]);
        check("wv_rdy", 16'(cmd_rdy), 16'd0);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check("wv_ign_clr", cmd, vx[idx % 12]);
    endtask

    // enters in HORZ, leaves in WAIT_H
    task automatic do_horz(input int idx);
        #1;
        check("h_cmd", cmd, hx[idx % 12]);
        check("h_rdy", 16'(cmd_rdy), 16'd1);
        check("h_idx", 16'(mv_indx), 16'(idx));
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check("wh_cmd", cmd, hx[idx % 12]);
        check("wh_rdy", 16'(cmd_rdy), 16'd0);
        check("wh_resp", 16'(resp), idx == 23 ? 16'hA5 : 16'h5A);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tour[i] = mvs[i % 12];
        rst = 1'b1; start_tour = 1'b0; cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; cmd_UART = 16'h0000; noise = 8'h00;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_idx", 16'(mv_indx), 16'd0);
        check("rst_rdy", 16'(cmd_rdy), 16'd0);
        check("rst_resp", 16'(resp), 16'hA5);
        cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
        #1;
        check("uart_cmd", cmd, 16'h2000);
        check("uart_rdy", 16'(cmd_rdy), 16'd1);
        check("uart_resp", 16'(resp), 16'hA5);
        clr_cmd_rdy = 1'b1;
        #1;
        check("uart_clr", 16'(clr_cmd_rdy_UART), 16'd1);
        step();
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        for (int i = 0; i < 24; i++) begin
            do_vert(i);
            resp_step();
            do_horz(i);
            resp_step();
        end
        cmd_UART = 16'h3456;
        #1;
        check("end_cmd", cmd, 16'h3456);
        check("end_resp", 16'(resp), 16'hA5);
        check("end_rdy", 16'(cmd_rdy), 16'd0);

        cmd_UART = 16'h2222; cmd_rdy_UART = 1'b1; start_tour = 1'b1;
        #1;
        check("pre_start_cmd", cmd, 16'h2222);
        step();
        start_tour = 1'b0;
        check("start_wins_cmd", cmd, 16'h4002);
        check("start_wins_idx", 16'(mv_indx), 16'd0);
`ifdef TOUR_CMD_UART_ABORT_EN
        step();
        check("abort_cmd", cmd, 16'h2222);
        check("abort_rdy", 16'(cmd_rdy), 16'd1);
        check("abort_resp", 16'(resp), 16'hA5);
        cmd_rdy_UART = 1'b0; start_tour = 1'b1;
        step();
        start_tour = 1'b0;
`endif
        for (int i = 0; i < 7; i++) begin
            do_vert(i);
            resp_step();
            do_horz(i);
            resp_step();
        end
        do_vert(7);
        cmd_rdy_UART = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_idx", 16'(mv_indx), 16'd0);
        check("mid_rst_rdy", 16'(cmd_rdy), 16'd1);
        check("mid_rst_cmd", cmd, 16'h2222);
        check("mid_rst_resp", 16'(resp), 16'hA5);
        cmd_rdy_UART = 1'b0;
        step();

        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        do_vert(0);
        resp_step();
        do_horz(0);
        resp_step();
        do_vert(1);
        resp_step();
        check("horz_pre_cmd", cmd, hx[1]);
        cmd_UART = 16'h7777; cmd_rdy_UART = 1'b1;
        step();
`ifdef TOUR_CMD_UART_ABORT_EN
        check("horz_abort_cmd", cmd, 16'h7777);
        check("horz_abort_idx", 16'(mv_indx), 16'd0);
        check("horz_abort_resp", 16'(resp), 16'hA5);
        cmd_rdy_UART = 1'b0;
`else
        check("horz_ign_cmd", cmd, hx[1]);
        check("horz_ign_rdy", 16'(cmd_rdy), 16'd1);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check("horz_ign_wh", cmd, hx[1]);
        resp_step();
        check("horz_ign_next", 16'(mv_indx), 16'd2);
        check("horz_ign_vcmd", cmd, vx[2]);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start_tour  input  1  one-cycle pulse; solved tour ready, begin replay.
REQ-004 move  input  8  one-hot knight move read from tour memory at mv_indx.
REQ-005 mv_indx  output  5  index of current tour move, 0..23.
REQ-006 cmd_UART  input  16  command from UART_wrapper.
REQ-007 cmd_rdy_UART  input  1  UART command valid.
REQ-008 clr_cmd_rdy_UART  output  1  clear to UART_wrapper.
REQ-009 clr_cmd_rdy  input  1  cmd_proc has accepted cmd.
REQ-010 send_resp  input  1  cmd_proc has completed a command.
REQ-011 cmd  output  16  command to cmd_proc.
REQ-012 cmd_rdy  output  1  cmd valid to cmd_proc.
REQ-013 resp  output  8  response byte to UART_wrapper.

Function
REQ-014 States SHALL be IDLE, VERT, WAIT_V, HORZ, WAIT_H.
REQ-015 In IDLE, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART and clr_cmd_rdy_UART=clr_cmd_rdy, all combinational; outside IDLE, clr_cmd_rdy_UART SHALL be 0.
REQ-016 IDLE with start_tour=1 SHALL clear mv_indx to 0 and enter VERT on the next edge; start_tour SHALL win over a simultaneous cmd_rdy_UART, which stays pending.
REQ-017 Tour-mode cmd_rdy SHALL be a flop, set on entry to VERT/HORZ and cleared on the edge after clr_cmd_rdy=1.
REQ-018 VERT + clr_cmd_rdy -> WAIT_V; WAIT_V + send_resp -> HORZ; HORZ + clr_cmd_rdy -> WAIT_H.
REQ-019 WAIT_H + send_resp: if mv_indx==23 -> IDLE, else mv_indx+1 and -> VERT.
REQ-020 Moves (bit: dx,dy): 0:+1,+2 1:-1,+2 2:-2,+1 3:-2,-1 4:-1,-2 5:+1,-2 6:+2,-1 7:+2,+1; lowest set bit wins; move==0 gives dx=dy=0.
REQ-021 Vertical cmd SHALL be {4'h4, heading, |dy|}; heading 8'h00 if dy>=0, 8'h7F if dy<0.
REQ-022 Horizontal cmd SHALL be {4'h5, heading, |dx|} (move with fanfare); heading 8'hBF if dx>=0, 8'h3F if dx<0.
REQ-023 cmd SHALL hold its value from the start of a leg until that leg's send_resp.
REQ-024 resp SHALL be 8'hA5 in IDLE and in WAIT_H with mv_indx==23; 8'h5A otherwise.
REQ-025 clr_cmd_rdy and send_resp seen in a state that does not expect them SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE, mv_indx=0 and tour cmd_rdy flop=0 at the next edge, including mid-tour; outputs then follow REQ-015.

Configuration
REQ-027 With TOUR_CMD_UART_ABORT_EN defined, cmd_rdy_UART=1 in any non-IDLE state SHALL force IDLE, clear the cmd_rdy flop and clear mv_indx on the next edge; the UART command then passes through.
REQ-028 Without it, cmd_rdy_UART SHALL be ignored outside IDLE and serviced after the tour ends.

Structure
REQ-029 Package tour_cmd_pkg SHALL hold the state enum, opcodes 4'h4 and 4'h5, the four heading constants and LAST_MOVE=23.
REQ-030 Combinational sub-module tour_move_decode SHALL map move to the vertical and horizontal 16-bit commands.

Verification
REQ-031 Reset, then cmd_rdy_UART=1 with cmd_UART=16'h2000 -> cmd=16'h2000, cmd_rdy=1, resp=8'hA5; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1.
REQ-032 start_tour with move=8'h01 -> next cycle cmd=16'h4002, cmd_rdy=1; after clr_cmd_rdy then send_resp -> cmd=16'h5BF1; resp=8'h5A.
REQ-033 move=8'h10 -> cmd=16'h47F2 then 16'h53F1; move=8'h06 -> bit 1 wins -> 16'h4002 then 16'h53F1.
REQ-034 Full 24-move replay -> mv_indx steps 0..23, resp=8'hA5 during final WAIT_H, then IDLE with UART pass-through.
REQ-035 rst pulse in WAIT_V at mv_indx=7 -> next cycle IDLE, mv_indx=0, cmd_rdy=cmd_rdy_UART.
REQ-036 cmd_rdy_UART=1 during HORZ -> with TOUR_CMD_UART_ABORT_EN: IDLE next cycle; without: ignored, tour continues, serviced after IDLE.
